stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICK_DIV, default 1024: clk cycles per counted second, legal range 2..2^20.
REQ-002 Parameter HOUR_MAX, default 24: hours count 0..HOUR_MAX-1, legal range 2..256.
REQ-003 Parameter HOUR_W, default 5: hour field width, SHALL satisfy 2^HOUR_W >= HOUR_MAX.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at full scale, 1 = stop at full scale.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start_stop  in  1  single-cycle pulse that toggles run/pause.
REQ-008 clear  in  1  single-cycle pulse that zeroes the watch; honoured only when paused.
REQ-009 lap  in  1  single-cycle pulse that captures the current time into the lap registers.
REQ-010 running  out  1  high in RUNNING state.
REQ-011 sec, min  out  6 each  seconds 0..59, minutes 0..59.
REQ-012 hour  out  HOUR_W  hours 0..HOUR_MAX-1.
REQ-013 lap_sec, lap_min  out  6 each; lap_hour  out  HOUR_W  last captured time.
REQ-014 lap_valid  out  1  one-cycle pulse after each capture.
REQ-015 overflow  out  1  sticky flag, set when full scale is reached.

Function
REQ-016 FSM states: IDLE (zeroed), RUNNING, PAUSED.
- IDLE + start_stop -> RUNNING.
- RUNNING + start_stop -> PAUSED.
- PAUSED + start_stop -> RUNNING.
- PAUSED + clear -> IDLE.
REQ-017 Prescaler counts 0..TICK_DIV-1 only in RUNNING, holds its value in PAUSED, and is zeroed in IDLE.
REQ-018 Tick = prescaler equal to TICK_DIV-1 in RUNNING; the tick wraps the prescaler to 0 and increments sec on the same edge.
REQ-019 Latency: when start_stop is sampled at edge k from IDLE, running=1 after edge k and sec=1 after edge k+TICK_DIV.
REQ-020 Cascade on tick:
- sec 59->0 carries into min.
- min 59->0 carries into hour.
- No field ever holds an out-of-range value.
REQ-021 Full scale is HOUR_MAX-1:59:59 plus a tick.
- SATURATE=0: all fields wrap to 0, overflow=1, state stays RUNNING.
- SATURATE=1: fields hold full scale, overflow=1, state -> PAUSED.
REQ-022 Pause/resume preserves prescaler phase, so total counted time excludes paused cycles exactly.
REQ-023 Lap in RUNNING or PAUSED latches sec/min/hour as they were before that edge; lap_valid=1 for the following cycle only.
- Lap in IDLE is ignored and lap_valid stays 0.
REQ-024 Clear in IDLE or RUNNING is ignored.
- Clear in PAUSED zeroes sec, min, hour, prescaler, lap registers and overflow.
REQ-025 Simultaneous events:
- Clear beats start_stop in PAUSED, so the result is IDLE.
- Lap with start_stop: both take effect.
- Lap with tick: lap gets the pre-increment value.
REQ-026 Repeated start_stop pulses on consecutive cycles each toggle the state; no pulse is lost.

Reset
REQ-027 On reset sampled high:
- State = IDLE and prescaler = 0.
- sec, min, hour, lap_sec, lap_min, lap_hour = 0.
- lap_valid, overflow, running = 0.
REQ-028 Reset has priority over every other input, including mid-count and mid-lap; the outputs are reset values on the cycle after the edge.

Structure
REQ-029 Package stopwatch_pkg SHALL hold the state enum (IDLE/RUNNING/PAUSED), SEC_MAX=59, MIN_MAX=59 and the 6-bit field width constant.
REQ-030 The prescaler SHALL be a sub-module sw_prescaler with inputs clk, reset, en, zero and output tick, parametrised by TICK_DIV.
REQ-031 The FSM, cascade counters and lap registers live in stopwatch_core; there are no combinational paths from inputs to outputs.

Verification (TICK_DIV=4, HOUR_MAX=2 unless noted)
REQ-032 Reset, then start_stop at edge 0 -> running=1 after edge 0; sec=1 after edge 4; sec=2 after edge 8.
REQ-033 Run to 0:00:59, then one tick -> sec=0, min=1; at 1:59:59 plus one tick -> all fields 0, overflow=1, running=1.
REQ-034 SATURATE=1, run to 1:59:59 plus one tick -> fields hold 1:59:59, overflow=1, running=0.
REQ-035 Pause for 100 cycles mid-second, then resume -> the next sec increment arrives at the remaining prescaler count, not after a full TICK_DIV.
REQ-036 Lap on the tick edge at 0:00:07 -> lap_sec=7, sec=8, lap_valid high for one cycle; lap in IDLE -> lap_valid stays 0.
REQ-037 Clear plus start_stop in PAUSED -> IDLE with all zeros; clear in RUNNING -> no effect; reset mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: state encoding, field limits, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this block).
package stopwatch_pkg;

  // Width of the seconds and minutes fields (0..59 fits in 6 bits).
  localparam int FIELD_W = 6;

  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

  // Watch operating states. IDLE always means "all counters zero".
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_e;

  // Modulo increment of a 0..maxv field; the caller decides whether a carry follows.
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] maxv);
    logic [FIELD_W-1:0] r;
    if (v >= maxv) begin
      r = '0;
    end else begin
      r = v + FIELD_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control pulses and time/lap outputs of the stopwatch, bundled for one port.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are fire-and-forget, outputs are always valid.
interface stopwatch_core_if #(
  parameter int HOUR_W = 5
);

  // Control pulses from the user side.
  logic                               start_stop;
  logic                               clear;
  logic                               lap;

  // Live time and status.
  logic                               running;
  logic [stopwatch_pkg::FIELD_W-1:0]  sec;
  logic [stopwatch_pkg::FIELD_W-1:0]  min;
  logic [HOUR_W-1:0]                  hour;

  // Last captured lap time.
  logic [stopwatch_pkg::FIELD_W-1:0]  lap_sec;
  logic [stopwatch_pkg::FIELD_W-1:0]  lap_min;
  logic [HOUR_W-1:0]                  lap_hour;
  logic                               lap_valid;

  // Sticky full-scale indication.
  logic                               overflow;

  // Controller side: issues pulses, observes time.
  modport master (
    output start_stop, clear, lap,
    input  running, sec, min, hour,
    input  lap_sec, lap_min, lap_hour, lap_valid,
    input  overflow
  );

  // Stopwatch side: consumes pulses, presents time.
  modport slave (
    input  start_stop, clear, lap,
    output running, sec, min, hour,
    output lap_sec, lap_min, lap_hour, lap_valid,
    output overflow
  );

endinterface

// File: rtl/sw_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; holds phase while disabled.
// Latency: tick is combinational from the count register, asserted in the cycle the count sits at TICK_DIV-1.
// Backpressure: none; en freezes the phase, zero forces the count back to 0.
module sw_prescaler #(
  parameter int TICK_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The tick is only meaningful while counting; a frozen count at LAST must not fire.
  assign tick = en && (cnt_q == LAST);

  // Next count: zero wins, otherwise advance and wrap on the tick, otherwise hold phase.
  always_comb begin
    cnt_d = cnt_q;
    if (zero) begin
      cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: run/pause/clear FSM, sec/min/hour cascade, lap capture and sticky overflow.
// Latency: every output is a register; a pulse sampled at edge k shows on the outputs after edge k.
// Backpressure: none; every pulse is acted on in the cycle it is sampled (or ignored by state rules).
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1024,
  parameter int HOUR_MAX = 24,
  parameter int HOUR_W   = 5,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            reset,
  stopwatch_core_if.slave sw
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_RUNNING = RUNNING;
  localparam logic [1:0] ST_PAUSED  = PAUSED;

  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

  logic [1:0]         state_q,     state_d;
  logic [FIELD_W-1:0] sec_q,       sec_d;
  logic [FIELD_W-1:0] min_q,       min_d;
  logic [HOUR_W-1:0]  hour_q,      hour_d;
  logic [FIELD_W-1:0] lap_sec_q,   lap_sec_d;
  logic [FIELD_W-1:0] lap_min_q,   lap_min_d;
  logic [HOUR_W-1:0]  lap_hour_q,  lap_hour_d;
  logic               lap_valid_q, lap_valid_d;
  logic               overflow_q,  overflow_d;

  logic st_idle;
  logic st_running;
  logic st_paused;
  logic clear_acc;
  logic full_scale;
  logic tick;

  assign st_idle    = (state_q == ST_IDLE);
  assign st_running = (state_q == ST_RUNNING);
  assign st_paused  = (state_q == ST_PAUSED);

  // Clear only means something while paused; elsewhere the pulse is dropped.
  assign clear_acc  = sw.clear && st_paused;

  // Last representable time; the next tick from here is the full-scale event.
  assign full_scale = (sec_q == SEC_MAX) && (min_q == MIN_MAX) && (hour_q == HOUR_LAST);

  // Prescaler runs only while RUNNING, keeps its phase across a pause, and is
  // forced to zero in IDLE and on an accepted clear.
  sw_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (st_running),
    .zero  (st_idle || clear_acc),
    .tick  (tick)
  );

  // Next-state for FSM, time cascade, lap capture and overflow; clear overrides all.
  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_hour_d  = lap_hour_q;
    lap_valid_d = 1'b0;
    overflow_d  = overflow_q;

    // Lap samples the registered time, so a lap on a tick edge sees the old value.
    if (sw.lap && !st_idle) begin
      lap_sec_d   = sec_q;
      lap_min_d   = min_q;
      lap_hour_d  = hour_q;
      lap_valid_d = 1'b1;
    end

    // Run/pause toggle; an unused encoding falls back to IDLE.
    case (state_q)
      ST_IDLE:    if (sw.start_stop) state_d = ST_RUNNING;
      ST_RUNNING: if (sw.start_stop) state_d = ST_PAUSED;
      ST_PAUSED:  if (sw.start_stop) state_d = ST_RUNNING;
      default:    state_d = ST_IDLE;
    endcase

    // One counted second: cascade through the fields, or handle full scale.
    if (tick) begin
      if (full_scale) begin
        overflow_d = 1'b1;
        if (SATURATE != 0) begin
          // Hold at full scale and stop counting.
          state_d = ST_PAUSED;
        end else begin
          // Roll over to zero and keep running.
          sec_d  = '0;
          min_d  = '0;
          hour_d = '0;
        end
      end else begin
        sec_d = wrap_inc(sec_q, SEC_MAX);
        if (sec_q == SEC_MAX) begin
          min_d = wrap_inc(min_q, MIN_MAX);
          if (min_q == MIN_MAX) begin
            hour_d = hour_q + HOUR_W'(1);
          end
        end
      end
    end

    // An accepted clear beats a simultaneous start_stop or lap and returns to IDLE.
    if (clear_acc) begin
      state_d     = ST_IDLE;
      sec_d       = '0;
      min_d       = '0;
      hour_d      = '0;
      lap_sec_d   = '0;
      lap_min_d   = '0;
      lap_hour_d  = '0;
      lap_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  // State registers; reset overrides every pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_hour_q  <= '0;
      lap_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_hour_q  <= lap_hour_d;
      lap_valid_q <= lap_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sw.running   = st_running;
  assign sw.sec       = sec_q;
  assign sw.min       = min_q;
  assign sw.hour      = hour_q;
  assign sw.lap_sec   = lap_sec_q;
  assign sw.lap_min   = lap_min_q;
  assign sw.lap_hour  = lap_hour_q;
  assign sw.lap_valid = lap_valid_q;
  assign sw.overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench: one wrapping and one saturating stopwatch driven with identical pulses.
// Expected outputs come from an elapsed-seconds model and are queued per cycle.
// A monitor pops and compares one entry per DUT after every rising edge.
module tb_stopwatch_core;

  localparam int TD = 4;
  localparam int HM = 2;
  localparam int HW = 1;
  localparam int FS = HM * 3600;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAU  = 2;

  typedef struct packed {
    logic          running;
    logic [5:0]    sec;
    logic [5:0]    min;
    logic [HW-1:0] hour;
    logic [5:0]    lap_sec;
    logic [5:0]    lap_min;
    logic [HW-1:0] lap_hour;
    logic          lap_valid;
    logic          overflow;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  stopwatch_core_if #(.HOUR_W(HW)) if_w ();
  stopwatch_core_if #(.HOUR_W(HW)) if_s ();

  stopwatch_core #(.TICK_DIV(TD), .HOUR_MAX(HM), .HOUR_W(HW), .SATURATE(0)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .sw    (if_w.slave)
  );

  stopwatch_core #(.TICK_DIV(TD), .HOUR_MAX(HM), .HOUR_W(HW), .SATURATE(1)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .sw    (if_s.slave)
  );

  always #5 clk = ~clk;

  // Reference model: state, prescaler phase, elapsed seconds, lap seconds, flags.
  int m_st[2];
  int m_p[2];
  int m_t[2];
  int m_lt[2];
  int m_lv[2];
  int m_ov[2];

  obs_t q0[$];
  obs_t q1[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_print = 0;

  task automatic model_step(input int d, input bit ss, input bit clr, input bit lp, input bit rst);
    int  st;
    int  nst;
    bit  tk;
    if (rst) begin
      m_st[d] = M_IDLE; m_p[d] = 0; m_t[d] = 0; m_lt[d] = 0; m_lv[d] = 0; m_ov[d] = 0;
      return;
    end
    st = m_st[d];
    tk = (st == M_RUN) && (m_p[d] == TD - 1);
    m_lv[d] = 0;
    if (clr && st == M_PAU) begin
      m_st[d] = M_IDLE; m_p[d] = 0; m_t[d] = 0; m_lt[d] = 0; m_ov[d] = 0;
      return;
    end
    if (lp && st != M_IDLE) begin
      m_lt[d] = m_t[d];
      m_lv[d] = 1;
    end
    if (st == M_RUN) m_p[d] = tk ? 0 : m_p[d] + 1;
    nst = st;
    if (ss) nst = (st == M_RUN) ? M_PAU : M_RUN;
    if (tk) begin
      if (m_t[d] == FS - 1) begin
        m_ov[d] = 1;
        if (d == 1) nst = M_PAU;
        else        m_t[d] = 0;
      end else begin
        m_t[d] = m_t[d] + 1;
      end
    end
    m_st[d] = nst;
  endtask

  function automatic obs_t expect_of(input int d);
    obs_t e;
    e.running   = (m_st[d] == M_RUN);
    e.sec       = 6'(m_t[d] % 60);
    e.min       = 6'((m_t[d] / 60) % 60);
    e.hour      = HW'(m_t[d] / 3600);
    e.lap_sec   = 6'(m_lt[d] % 60);
    e.lap_min   = 6'((m_lt[d] / 60) % 60);
    e.lap_hour  = HW'(m_lt[d] / 3600);
    e.lap_valid = (m_lv[d] != 0);
    e.overflow  = (m_ov[d] != 0);
    return e;
  endfunction

  function automatic obs_t snap(input int d);
    obs_t o;
    if (d == 0) begin
      o.running = if_w.running; o.sec = if_w.sec; o.min = if_w.min; o.hour = if_w.hour;
      o.lap_sec = if_w.lap_sec; o.lap_min = if_w.lap_min; o.lap_hour = if_w.lap_hour;
      o.lap_valid = if_w.lap_valid; o.overflow = if_w.overflow;
    end else begin
      o.running = if_s.running; o.sec = if_s.sec; o.min = if_s.min; o.hour = if_s.hour;
      o.lap_sec = if_s.lap_sec; o.lap_min = if_s.lap_min; o.lap_hour = if_s.lap_hour;
      o.lap_valid = if_s.lap_valid; o.overflow = if_s.overflow;
    end
    return o;
  endfunction

  // One clock of stimulus: drive pulses away from the edge, advance model, queue expectation.
  task automatic cyc(input bit ss, input bit clr, input bit lp, input bit rst);
    @(negedge clk);
    reset = rst;
    if_w.start_stop = ss; if_w.clear = clr; if_w.lap = lp;
    if_s.start_stop = ss; if_s.clear = clr; if_s.lap = lp;
    for (int d = 0; d < 2; d++) model_step(d, ss, clr, lp, rst);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  task automatic compare(input int d, input obs_t e);
    obs_t a;
    a = snap(d);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      if (n_print < 30) begin
        n_print++;
        $display("FAIL outputs dut=%0d t=%0t got run=%0b %0d:%0d:%0d lap=%0d:%0d:%0d lv=%0b ov=%0b, required run=%0b %0d:%0d:%0d lap=%0d:%0d:%0d lv=%0b ov=%0b",
                 d, $time, a.running, a.hour, a.min, a.sec, a.lap_hour, a.lap_min, a.lap_sec,
                 a.lap_valid, a.overflow, e.running, e.hour, e.min, e.sec, e.lap_hour, e.lap_min,
                 e.lap_sec, e.lap_valid, e.overflow);
      end
    end
  endtask

  // Monitor: after each rising edge, check whatever expectations were queued for it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) compare(0, q0.pop_front());
      if (q1.size() > 0) compare(1, q1.pop_front());
    end
  end

  initial begin
    int guard;
    bit clr;
    reset = 1'b0;
    if_w.start_stop = 1'b0; if_w.clear = 1'b0; if_w.lap = 1'b0;
    if_s.start_stop = 1'b0; if_s.clear = 1'b0; if_s.lap = 1'b0;

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Start from IDLE, watch the first two seconds arrive.
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);

    // Pause mid-second for 100 cycles, then resume.
    cyc(1, 0, 0, 0);
    repeat (100) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0);

    // Clear while running is ignored.
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Lap exactly on the tick edge that moves 0:00:07 to 0:00:08.
    guard = 0;
    while (!(m_st[0] == M_RUN && m_t[0] == 7 && m_p[0] == TD - 1) && guard < 200) begin
      cyc(0, 0, 0, 0);
      guard++;
    end
    n_cmp++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL lap_tick_setup got guard=%0d required below 200", guard);
    end
    cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Lap together with start_stop: pause and capture.
    cyc(1, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Clear together with start_stop while paused: clear wins.
    cyc(1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Lap in IDLE is ignored.
    cyc(0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0);

    // Back-to-back toggles, then reset mid-run together with a lap.
    repeat (3) cyc(1, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, 0);

    // Full-scale run: wrap instance rolls over, saturating instance stops.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < FS * TD + 40; i++) begin
      cyc(0, 0, ($urandom % 512) == 0, 0);
    end

    // Randomised pulses with occasional resets.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      clr = ($urandom % 10) == 0;
      cyc(($urandom % 12) == 0, clr, !clr && (($urandom % 8) == 0), ($urandom % 700) == 0);
    end

    repeat (3) cyc(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain got pending=%0d/%0d required 0/0", q0.size(), q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
